// File: rtl/scan_controller.sv
// Frame-load / window-scan sequencer for the template-matching datapath.
// Define SCAN_CONTROLLER_BEST_EN to add the in-block minimum-SAD tracker (best_x/best_y/best_sad).
module scan_controller #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int TPL_W = 40,
   parameter int TPL_H = 100,
   parameter int X_W   = 10,
   parameter int Y_W   = 9,
   parameter int SAD_W = 12,
   parameter int CNT_W = 19
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             pix_in,
   input  logic             pix_valid,
   output logic             pix_ready,
   output logic             lb_d,
   output logic             lb_ena,
   output logic             cmp_req,
   input  logic             cmp_done,
   input  logic [SAD_W-1:0] sad_in,
   output logic [X_W-1:0]   win_x,
   output logic [Y_W-1:0]   win_y,
   output logic             busy,
   output logic             done
`ifdef SCAN_CONTROLLER_BEST_EN
   ,
   output logic [X_W-1:0]   best_x,
   output logic [Y_W-1:0]   best_y,
   output logic [SAD_W-1:0] best_sad
`endif
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_CMP   = 3'd2;
   localparam logic [2:0] S_SHIFT = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [X_W-1:0]   X_LAST   = X_W'(IMG_W - 1);
   localparam logic [X_W-1:0]   X_MAX    = X_W'(IMG_W - TPL_W);
   localparam logic [Y_W-1:0]   Y_MAX    = Y_W'(IMG_H - TPL_H);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMG_W * IMG_H - 1);

   logic [2:0]       state;
   logic [CNT_W-1:0] pix_cnt;
   logic [X_W-1:0]   nx;
   logic [Y_W-1:0]   ny;
   logic             xfer, last_pos, start_ok, accept;

   assign xfer     = (state == S_LOAD) && pix_valid;
   assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
   assign accept   = (state == S_CMP) && cmp_done;
   assign last_pos = (win_x == X_MAX) && (win_y == Y_MAX);

   assign pix_ready = (state == S_LOAD);
   assign lb_ena    = xfer || (state == S_SHIFT);
   assign lb_d      = xfer && pix_in;
   assign cmp_req   = (state == S_CMP);
   assign busy      = (state == S_LOAD) || (state == S_CMP) || (state == S_SHIFT);
   assign done      = (state == S_DONE);

   // Raster advance: the window walks off the right edge and wraps one row down.
   always_comb begin
      nx = win_x + X_W'(1);
      ny = win_y;
      if (win_x == X_LAST) begin
         nx = '0;
         ny = win_y + Y_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         pix_cnt <= '0;
         win_x   <= '0;
         win_y   <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state   <= S_LOAD;
                  pix_cnt <= '0;
                  win_x   <= '0;
                  win_y   <= '0;
               end
            end
            S_LOAD: begin
               if (xfer) begin
                  pix_cnt <= pix_cnt + CNT_W'(1);
                  if (pix_cnt == CNT_LAST) state <= S_CMP;
               end
            end
            S_CMP: begin
               if (cmp_done) state <= last_pos ? S_DONE : S_SHIFT;
            end
            S_SHIFT: begin
               win_x <= nx;
               win_y <= ny;
               state <= ((nx <= X_MAX) && (ny <= Y_MAX)) ? S_CMP : S_SHIFT;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef SCAN_CONTROLLER_BEST_EN
   // Strict compare keeps the earliest raster position on ties.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         best_x   <= '0;
         best_y   <= '0;
         best_sad <= '1;
      end else if (start_ok) begin
         best_x   <= '0;
         best_y   <= '0;
         best_sad <= '1;
      end else if (accept && (sad_in < best_sad)) begin
         best_x   <= win_x;
         best_y   <= win_y;
         best_sad <= sad_in;
      end
   end
`else
   logic unused_best;
   assign unused_best = start_ok ^ accept ^ (^sad_in);
`endif

endmodule
